reg_file: RTL and testbench

- 8-entry x 8-bit general-purpose register file for the 8-bit CPU datapath.
- One synchronous write port and two independent combinational read ports, e.g. source operands A/B.
- Register 0 is hardwired to zero.
- Sits between the decode stage (addresses) and the ALU (operands) / writeback (write data).

---
 rtl/reg_file_if.sv | 25 ++
 rtl/reg_file.sv | 96 +++++++++
 tb/tb_reg_file.sv | 192 +++++++++++++++++++
 3 files changed

// File: rtl/reg_file_if.sv
// Bus bundle for reg_file: write port plus two read ports.
// The master side is the decode/writeback logic, the slave side is the register file.
`timescale 1ns/1ps
interface reg_file_if #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
);
    logic              RF_w_en;
    logic [ADDR_W-1:0] r_addr_0;
    logic [ADDR_W-1:0] r_addr_1;
    logic [ADDR_W-1:0] w_addr;
    logic [DATA_W-1:0] w_data;
    logic [DATA_W-1:0] o_r_data_0;
    logic [DATA_W-1:0] o_r_data_1;

    modport master (
        output RF_w_en, r_addr_0, r_addr_1, w_addr, w_data,
        input  o_r_data_0, o_r_data_1
    );

    modport slave (
        input  RF_w_en, r_addr_0, r_addr_1, w_addr, w_data,
        output o_r_data_0, o_r_data_1
    );
endinterface

// File: rtl/reg_file.sv
// 8x8 register file: one synchronous write port, two combinational read ports, R0 reads zero.
// Optional macro RF_BYPASS_EN enables write-first forwarding onto the read ports.
`timescale 1ns/1ps
module reg_file #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 3
) (
    input  logic         clk,
    input  logic         rst,
    reg_file_if.slave    rf
);
    localparam int NUM_REGS = 2 ** ADDR_W;

    logic [DATA_W-1:0] regs_r [NUM_REGS];
    logic              wr_valid_s;
    logic              hit_0_s;
    logic              hit_1_s;
    logic [DATA_W-1:0] r_data_0_s;
    logic [DATA_W-1:0] r_data_1_s;

    // Resolves one read port; address 0 is never backed by storage.
    function automatic logic [DATA_W-1:0] select_read(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              hit,
        input logic [DATA_W-1:0] fwd_data
    );
        logic [DATA_W-1:0] val;
        if (addr == {ADDR_W{1'b0}}) begin
            val = {DATA_W{1'b0}};
        end else if (hit) begin
            val = fwd_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Qualify the write: reset and writes to R0 are both discarded.
    always_comb begin
        wr_valid_s = 1'b0;
        if (!rst && rf.RF_w_en && (rf.w_addr != {ADDR_W{1'b0}})) begin
            wr_valid_s = 1'b1;
        end else begin
            wr_valid_s = 1'b0;
        end
    end

    // Storage update; reset clears every entry asynchronously.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs_r[i] <= {DATA_W{1'b0}};
            end
        end else if (wr_valid_s) begin
            regs_r[rf.w_addr] <= rf.w_data;
        end
    end

    // Forwarding hit detection for each read port.
    always_comb begin
        hit_0_s = 1'b0;
        hit_1_s = 1'b0;
`ifdef RF_BYPASS_EN
        if (wr_valid_s && (rf.r_addr_0 == rf.w_addr)) begin
            hit_0_s = 1'b1;
        end else begin
            hit_0_s = 1'b0;
        end
        if (wr_valid_s && (rf.r_addr_1 == rf.w_addr)) begin
            hit_1_s = 1'b1;
        end else begin
            hit_1_s = 1'b0;
        end
`else
        hit_0_s = 1'b0;
        hit_1_s = 1'b0;
`endif
    end

    // Read ports; forced to zero while reset is held so no stale data leaks out.
    always_comb begin
        r_data_0_s = {DATA_W{1'b0}};
        r_data_1_s = {DATA_W{1'b0}};
        if (rst) begin
            r_data_0_s = {DATA_W{1'b0}};
            r_data_1_s = {DATA_W{1'b0}};
        end else begin
            r_data_0_s = select_read(rf.r_addr_0, regs_r[rf.r_addr_0], hit_0_s, rf.w_data);
            r_data_1_s = select_read(rf.r_addr_1, regs_r[rf.r_addr_1], hit_1_s, rf.w_data);
        end
    end

    assign rf.o_r_data_0 = r_data_0_s;
    assign rf.o_r_data_1 = r_data_1_s;
endmodule

// File: tb/tb_reg_file.sv
// Directed and random self-checking bench for reg_file against a scoreboard of R0..R7.
`timescale 1ns/1ps
module tb_reg_file;
    logic clk;
    logic rst;
    int   checks;
    int   errors;
    logic [7:0] sb [8];

    reg_file_if #(.DATA_W(8), .ADDR_W(3)) rf_bus ();

    reg_file #(.DATA_W(8), .ADDR_W(3)) dut (
        .clk (clk),
        .rst (rst),
        .rf  (rf_bus.slave)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check_val(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s got %02h expected %02h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected read value before the edge, given the write currently presented.
    function automatic logic [7:0] exp_read(input logic [2:0] a);
        logic [7:0] v;
        v = (a == 3'd0) ? 8'h00 : sb[a];
`ifdef RF_BYPASS_EN
        if (rf_bus.RF_w_en && rf_bus.w_addr != 3'd0 && a == rf_bus.w_addr && a != 3'd0)
            v = rf_bus.w_data;
`endif
        return v;
    endfunction

    task automatic sweep(input string tag, input logic zero_exp);
        rf_bus.RF_w_en = 1'b0;
        for (int a = 0; a < 8; a++) begin
            rf_bus.r_addr_0 = a[2:0];
            rf_bus.r_addr_1 = 3'(7 - a);
            #0.5;
            check_val({tag, "_p0"}, rf_bus.o_r_data_0, zero_exp ? 8'h00 : sb[a]);
            check_val({tag, "_p1"}, rf_bus.o_r_data_1, zero_exp ? 8'h00 : sb[7 - a]);
        end
    endtask

    task automatic write_reg(input logic [2:0] a, input logic [7:0] d);
        rf_bus.RF_w_en = 1'b1;
        rf_bus.w_addr  = a;
        rf_bus.w_data  = d;
        tick();
        if (a != 3'd0) sb[a] = d;
        rf_bus.RF_w_en = 1'b0;
    endtask

    // Reset pulse of 5 ns placed between edges, with all addresses checked while held.
    task automatic reset_pulse(input string tag);
        rst = 1'b1;
        sweep({tag, "_in_rst"}, 1'b1);
        #1;
        rst = 1'b0;
        for (int i = 0; i < 8; i++) sb[i] = 8'h00;
        #0.5;
        sweep({tag, "_after_rst"}, 1'b0);
    endtask

    task automatic random_run(input int n);
        logic [7:0] d;
        for (int c = 0; c < n; c++) begin
            rf_bus.RF_w_en  = 1'($urandom_range(1, 0));
            rf_bus.w_addr   = 3'($urandom_range(7, 0));
            d               = 8'($urandom_range(255, 0));
            rf_bus.w_data   = d;
            rf_bus.r_addr_0 = 3'($urandom_range(7, 0));
            rf_bus.r_addr_1 = 3'($urandom_range(7, 0));
            #1;
            check_val("rand_p0", rf_bus.o_r_data_0, exp_read(rf_bus.r_addr_0));
            check_val("rand_p1", rf_bus.o_r_data_1, exp_read(rf_bus.r_addr_1));
            tick();
            if (rf_bus.RF_w_en && rf_bus.w_addr != 3'd0) sb[rf_bus.w_addr] = d;
        end
        rf_bus.RF_w_en = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        for (int i = 0; i < 8; i++) sb[i] = 8'h00;
        rst             = 1'b1;
        rf_bus.RF_w_en  = 1'b0;
        rf_bus.w_addr   = 3'd0;
        rf_bus.w_data   = 8'h00;
        rf_bus.r_addr_0 = 3'd0;
        rf_bus.r_addr_1 = 3'd0;

        // Power-on reset with a write presented: must be ignored.
        rf_bus.RF_w_en = 1'b1;
        rf_bus.w_addr  = 3'd2;
        rf_bus.w_data  = 8'h77;
        tick();
        sweep("por", 1'b1);
        rst = 1'b0;
        #1;

        // Fill R1..R7 with 0xAA, then reset between edges.
        for (int a = 1; a < 8; a++) write_reg(3'(a), 8'hAA);
        sweep("fill_aa", 1'b0);
        tick();
        reset_pulse("rst_pulse");

        // R0 protection.
        write_reg(3'd0, 8'hFF);
        rf_bus.r_addr_0 = 3'd0;
        rf_bus.r_addr_1 = 3'd0;
        #1;
        check_val("r0_p0", rf_bus.o_r_data_0, 8'h00);
        check_val("r0_p1", rf_bus.o_r_data_1, 8'h00);

        // Basic write/read and port swap.
        write_reg(3'd3, 8'h5C);
        write_reg(3'd7, 8'hFF);
        rf_bus.r_addr_0 = 3'd3;
        rf_bus.r_addr_1 = 3'd7;
        #1;
        check_val("basic_p0", rf_bus.o_r_data_0, 8'h5C);
        check_val("basic_p1", rf_bus.o_r_data_1, 8'hFF);
        rf_bus.r_addr_0 = 3'd7;
        rf_bus.r_addr_1 = 3'd3;
        #1;
        check_val("swap_p0", rf_bus.o_r_data_0, 8'hFF);
        check_val("swap_p1", rf_bus.o_r_data_1, 8'h5C);
        rf_bus.r_addr_1 = 3'd7;
        #1;
        check_val("same_p0", rf_bus.o_r_data_0, 8'hFF);
        check_val("same_p1", rf_bus.o_r_data_1, 8'hFF);

        // Enable gating.
        rf_bus.RF_w_en  = 1'b0;
        rf_bus.w_addr   = 3'd4;
        rf_bus.w_data   = 8'h12;
        rf_bus.r_addr_0 = 3'd4;
        tick();
        tick();
        tick();
        check_val("gate_r4", rf_bus.o_r_data_0, 8'h00);

        // Collision on R5 (old value 0x00).
        rf_bus.r_addr_0 = 3'd5;
        rf_bus.r_addr_1 = 3'd5;
        rf_bus.w_addr   = 3'd5;
        rf_bus.w_data   = 8'h3C;
        rf_bus.RF_w_en  = 1'b1;
        #1;
`ifdef RF_BYPASS_EN
        check_val("coll_pre_p0", rf_bus.o_r_data_0, 8'h3C);
        check_val("coll_pre_p1", rf_bus.o_r_data_1, 8'h3C);
`else
        check_val("coll_pre_p0", rf_bus.o_r_data_0, 8'h00);
        check_val("coll_pre_p1", rf_bus.o_r_data_1, 8'h00);
`endif
        tick();
        rf_bus.RF_w_en = 1'b0;
        sb[5] = 8'h3C;
        #1;
        check_val("coll_post_p0", rf_bus.o_r_data_0, 8'h3C);
        check_val("coll_post_p1", rf_bus.o_r_data_1, 8'h3C);

        // Random regression, sweeps, mid-run reset, repeat.
        random_run(150);
        sweep("sweep150", 1'b0);
        random_run(1000);
        sweep("sweep1000", 1'b0);
        tick();
        reset_pulse("mid_rst");
        random_run(150);
        sweep("sweep_post_rst", 1'b0);
        random_run(1000);
        sweep("sweep_final", 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
